// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit:
// FSM states, load funct3 codes and store size patterns.
package mem_lsu_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] SP_NONE = 4'b0000;
  localparam logic [3:0] SP_SB   = 4'b0001;
  localparam logic [3:0] SP_SH   = 4'b0011;
  localparam logic [3:0] SP_SW   = 4'b1111;

endpackage

// File: rtl/mem_lsu_load_align.sv
// Load data alignment: picks the byte/half addressed by the
// low address bits and sign- or zero-extends it per funct3.
module lsu_load_align
  import mem_lsu_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] rdata,
  input  logic [1:0]            off,
  input  logic [2:0]            sel,
  output logic [WORD_WIDTH-1:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    unique case (sel)
      F3_LB:   ext = {{24{b[7]}}, b};
      F3_LBU:  ext = {24'd0, b};
      F3_LH:   ext = {{16{h[15]}}, h};
      F3_LHU:  ext = {16'd0, h};
      F3_LW:   ext = rdata;
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage LSU: req/gnt/rvalid handshake with the data
// cache, store lane placement, load extraction and stall.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = WORD_WIDTH
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              hold_in,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [3:0]        dm_write,
  input  logic [2:0]        dm_select,
  output logic              dc_req,
  output logic              dc_we,
  output logic [3:0]        dc_be,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [WORD_W-1:0] dc_wdata,
  input  logic              dc_gnt,
  input  logic              dc_rvalid,
  input  logic [WORD_W-1:0] dc_rdata,
  output logic              stall,
  output logic [WORD_W-1:0] load_data,
  output logic              misalign
);

  lsu_state_e state, state_nx;

  logic              access;
  logic              mis;
  logic              start;
  logic              capture;
  logic [1:0]        off_q;
  logic [2:0]        sel_q;
  logic [3:0]        be_nx;
  logic [WORD_W-1:0] wd_nx;
  logic [WORD_W-1:0] ext;

  // A load wins over a (illegal) simultaneous store pattern.
  always_comb begin
    access = ld_en | (dm_write != SP_NONE);
    mis    = 1'b0;
    if (ld_en) begin
      unique case (1'b1)
        (dm_select[1:0] == 2'b00): mis = 1'b0;
        (dm_select[1:0] == 2'b01): mis = addr[0];
        default:                   mis = |addr[1:0];
      endcase
    end else begin
      unique case (1'b1)
        (dm_write == SP_SH): mis = addr[0];
        (dm_write == SP_SW): mis = |addr[1:0];
        default:             mis = 1'b0;
      endcase
    end
  end

  always_comb begin
    be_nx = ld_en ? 4'b0000 : dm_write << addr[1:0];
    unique case (dm_write)
      SP_SB:   wd_nx = {4{wdata[7:0]}};
      SP_SH:   wd_nx = {2{wdata[15:0]}};
      default: wd_nx = wdata;
    endcase
  end

  lsu_load_align u_align (
    .rdata (dc_rdata),
    .off   (off_q),
    .sel   (sel_q),
    .ext   (ext)
  );

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    misalign = 1'b0;
    dc_req   = 1'b0;
    start    = 1'b0;
    capture  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        misalign = access & mis;
        stall    = access & ~mis & ~flush;
        start    = stall;
        if (start) state_nx = ST_REQ;
      end
      ST_REQ: begin
        dc_req = 1'b1;
        stall  = 1'b1;
        if (!dc_gnt) begin
          if (flush) state_nx = ST_IDLE;
        end else if (dc_we) begin
          state_nx = ST_DONE;
        end else if (dc_rvalid) begin
          capture  = ~flush;
          state_nx = flush ? ST_IDLE : ST_DONE;
        end else begin
          state_nx = flush ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (dc_rvalid) begin
          capture  = ~flush;
          state_nx = flush ? ST_IDLE : ST_DONE;
        end else if (flush) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        stall = 1'b1;
        if (dc_rvalid) state_nx = ST_IDLE;
      end
      ST_DONE: begin
        if (!hold_in) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (!nrst) begin
      stall    = 1'b0;
      misalign = 1'b0;
      dc_req   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      dc_we     <= 1'b0;
      dc_be     <= 4'b0000;
      dc_addr   <= '0;
      dc_wdata  <= '0;
      load_data <= '0;
      off_q     <= 2'b00;
      sel_q     <= 3'b000;
    end else begin
      state <= state_nx;
      if (start) begin
        dc_we    <= ~ld_en;
        dc_be    <= be_nx;
        dc_addr  <= {addr[ADDR_W-1:2], 2'b00};
        dc_wdata <= wd_nx;
        off_q    <= addr[1:0];
        sel_q    <= dm_select;
      end
      if (capture) load_data <= ext;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed loads/stores
// against a bench-side cache responder and reference model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        flush = 1'b0;
  logic        hold_in = 1'b0;
  logic        ld_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  dm_write = '0;
  logic [2:0]  dm_select = '0;
  logic        dc_req, dc_we;
  logic [3:0]  dc_be;
  logic [31:0] dc_addr, dc_wdata;
  logic        dc_gnt = 1'b0;
  logic        dc_rvalid = 1'b0;
  logic [31:0] dc_rdata;
  logic        stall, misalign;
  logic [31:0] load_data;

  mem_lsu dut (
    .clk(clk), .nrst(nrst), .flush(flush), .hold_in(hold_in),
    .ld_en(ld_en), .addr(addr), .wdata(wdata),
    .dm_write(dm_write), .dm_select(dm_select),
    .dc_req(dc_req), .dc_we(dc_we), .dc_be(dc_be),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .stall(stall), .load_data(load_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ld_size(input logic [2:0] s);
    case (s[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int st_size(input logic [3:0] d);
    if (d == 4'b0001) return 1;
    if (d == 4'b0011) return 2;
    return 4;
  endfunction

  function automatic logic mdl_mis(input logic ld, input logic [31:0] a,
                                   input logic [3:0] dw, input logic [2:0] s);
    int sz;
    if (!ld && dw == 4'b0000) return 1'b0;
    sz = ld ? ld_size(s) : st_size(dw);
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] rd,
                                           input logic [1:0] off,
                                           input logic [2:0] s);
    int sz;
    logic [31:0] v;
    sz = ld_size(s);
    v  = rd >> (8 * int'(off));
    if (sz == 1) v = s[2] ? (v & 32'hFF) : {{24{v[7]}}, v[7:0]};
    else if (sz == 2) v = s[2] ? (v & 32'hFFFF) : {{16{v[15]}}, v[15:0]};
    else v = rd;
    return v;
  endfunction

  logic [31:0] exp_addr, exp_wd, exp_load;
  logic [3:0]  exp_be;
  logic        exp_we;

  task automatic set_exp(input logic ld, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] dw,
                         input logic [2:0] s, input logic [31:0] rd);
    int sz, off;
    off      = int'(a[1:0]);
    sz       = st_size(dw);
    exp_addr = a & 32'hFFFF_FFFC;
    exp_we   = !ld && dw != 4'b0000;
    exp_be   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (exp_we && i >= off && i < off + sz) exp_be[i] = 1'b1;
      exp_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
    end
    exp_load = mdl_load(rd, a[1:0], s);
  endtask

  // ---------------- cache responder ----------------
  int gnt_dly = 0, rv_dly = 1, gc = 0, rc = 0;
  bit pend = 0, rv_force = 0;
  logic [31:0] cache_rdata = '0;
  assign dc_rdata = cache_rdata;

  always @(negedge clk) begin
    dc_gnt    = 1'b0;
    dc_rvalid = rv_force;
    if (!nrst) begin
      gc   = 0;
      pend = 0;
    end else begin
      if (pend) begin
        if (rc == 0) begin
          dc_rvalid = 1'b1;
          pend = 0;
        end else rc--;
      end
      if (dc_req) begin
        if (gc >= gnt_dly) begin
          dc_gnt = 1'b1;
          gc = 0;
          if (!dc_we) begin
            if (rv_dly == 0) dc_rvalid = 1'b1;
            else begin
              pend = 1;
              rc = rv_dly - 1;
            end
          end
        end else gc++;
      end else gc = 0;
    end
  end

  // ---------------- compare process ----------------
  int  req_cnt = 0;
  bit  ld_chk = 0;
  bit  stall_prev = 0;
  logic [31:0] last_addr, last_wd;
  logic [3:0]  last_be;
  logic        last_we;

  always @(negedge clk) begin
    if (nrst && dc_req) begin
      req_cnt++;
      chk("req dc_addr", dc_addr, exp_addr);
      chk("req dc_we", {31'd0, dc_we}, {31'd0, exp_we});
      chk("req dc_be", {28'd0, dc_be}, {28'd0, exp_be});
      if (exp_we) chk("req dc_wdata", dc_wdata, exp_wd);
      last_addr = dc_addr;
      last_wd   = dc_wdata;
      last_be   = dc_be;
      last_we   = dc_we;
    end
    if (nrst && ld_chk && stall_prev && !stall) begin
      chk("model load_data", load_data, exp_load);
      ld_chk = 0;
    end
    stall_prev = stall;
  end

  // ---------------- directed operations ----------------
  task automatic run_op(input string nm, input logic ld,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] dw, input logic [2:0] s,
                        input int gd, input int rd,
                        input logic [31:0] rdat, input int exp_st,
                        input int hold_cyc, input logic [31:0] lit);
    int n, rq;
    logic mis;
    set_exp(ld, a, wd, dw, s, rdat);
    mis = mdl_mis(ld, a, dw, s);
    gnt_dly = gd;
    rv_dly = rd;
    cache_rdata = rdat;
    ld_chk = ld & ~mis;
    rq = req_cnt;
    @(posedge clk); #1;
    ld_en = ld; addr = a; wdata = wd;
    dm_write = dw; dm_select = s;
    hold_in = (hold_cyc > 0);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) chk({nm, " misalign"}, {31'd0, misalign}, {31'd0, mis});
      if (!stall) break;
      n++;
    end
    chk({nm, " stall cycles"}, n, exp_st);
    if (ld && !mis) chk({nm, " load_data"}, load_data, lit);
    for (int k = 0; k < hold_cyc; k++) begin
      @(posedge clk); #1;
      if (k == hold_cyc - 1) hold_in = 1'b0;
      @(negedge clk);
      chk({nm, " hold load_data"}, load_data, lit);
      chk({nm, " hold stall"}, {31'd0, stall}, 32'd0);
      chk({nm, " hold dc_req"}, {31'd0, dc_req}, 32'd0);
    end
    @(posedge clk); #1;
    ld_en = 0; dm_write = 0; hold_in = 0;
    @(negedge clk);
    if (mis) chk({nm, " no request"}, req_cnt, rq);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " dc_req"}, {31'd0, dc_req}, 32'd0);
    chk({nm, " dc_we"}, {31'd0, dc_we}, 32'd0);
    chk({nm, " dc_be"}, {28'd0, dc_be}, 32'd0);
    chk({nm, " dc_addr"}, dc_addr, 32'd0);
    chk({nm, " dc_wdata"}, dc_wdata, 32'd0);
    chk({nm, " load_data"}, load_data, 32'd0);
    chk({nm, " stall"}, {31'd0, stall}, 32'd0);
    chk({nm, " misalign"}, {31'd0, misalign}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rq;
    logic [31:0] keep;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    nrst = 1'b1;

    run_op("SW", 0, 32'h100, 32'hDEADBEEF, 4'b1111, 3'b000,
           0, 1, 0, 2, 0, 0);
    chk("SW addr", last_addr, 32'h100);
    chk("SW be", {28'd0, last_be}, 32'hF);
    chk("SW we", {31'd0, last_we}, 32'd1);

    run_op("SB", 0, 32'h103, 32'h000000A5, 4'b0001, 3'b000,
           0, 1, 0, 2, 0, 0);
    chk("SB be", {28'd0, last_be}, 32'h8);
    chk("SB wdata", last_wd, 32'hA5A5A5A5);
    chk("SB addr", last_addr, 32'h100);

    run_op("SH", 0, 32'h102, 32'h1234ABCD, 4'b0011, 3'b000,
           2, 1, 0, 4, 0, 0);
    chk("SH be", {28'd0, last_be}, 32'hC);
    chk("SH wdata", last_wd, 32'hABCDABCD);

    run_op("LB", 1, 32'h102, 0, 4'b0000, 3'b000,
           0, 3, 32'h12F45678, 5, 0, 32'hFFFFFFF4);
    run_op("LBU", 1, 32'h102, 0, 4'b0000, 3'b100,
           0, 1, 32'h12F45678, 3, 0, 32'h000000F4);
    run_op("LH", 1, 32'h102, 0, 4'b0000, 3'b001,
           0, 0, 32'h12F45678, 2, 0, 32'h000012F4);
    run_op("LHU", 1, 32'h100, 0, 4'b0000, 3'b101,
           0, 1, 32'h12348765, 3, 0, 32'h00008765);
    run_op("LH0", 1, 32'h100, 0, 4'b0000, 3'b001,
           0, 1, 32'h12348765, 3, 0, 32'hFFFF8765);
    run_op("LW", 1, 32'h104, 0, 4'b0000, 3'b010,
           0, 2, 32'hCAFEF00D, 4, 0, 32'hCAFEF00D);
    run_op("LW mis", 1, 32'h101, 0, 4'b0000, 3'b010,
           0, 1, 32'h0, 0, 0, 0);
    run_op("SH mis", 0, 32'h005, 32'h1111, 4'b0011, 3'b000,
           0, 1, 32'h0, 0, 0, 0);
    run_op("LW hold", 1, 32'h108, 0, 4'b0000, 3'b010,
           0, 1, 32'h5A5A1234, 3, 3, 32'h5A5A1234);

    // flush while the request is still waiting for a grant
    set_exp(1, 32'h200, 0, 4'b0000, 3'b010, 32'h0);
    ld_chk = 0;
    gnt_dly = 1000;
    @(posedge clk); #1;
    ld_en = 1; addr = 32'h200; dm_select = 3'b010;
    @(negedge clk);
    chk("flushreq idle stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    flush = 1; ld_en = 0;
    @(negedge clk);
    chk("flushreq dc_req", {31'd0, dc_req}, 32'd1);
    @(posedge clk); #1;
    flush = 0;
    rq = req_cnt;
    @(negedge clk);
    chk("flushreq dc_req drop", {31'd0, dc_req}, 32'd0);
    chk("flushreq stall", {31'd0, stall}, 32'd0);
    repeat (2) @(negedge clk);
    chk("flushreq no retry", req_cnt, rq);
    gnt_dly = 0;

    // flush during WAIT: drain the late response, keep old data
    keep = 32'h5A5A1234;
    set_exp(1, 32'h300, 0, 4'b0000, 3'b010, 32'h11111111);
    ld_chk = 0;
    rv_dly = 4;
    cache_rdata = 32'h11111111;
    @(posedge clk); #1;
    ld_en = 1; addr = 32'h300; dm_select = 3'b010;
    @(negedge clk);
    chk("drain c1 stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain c2 dc_req", {31'd0, dc_req}, 32'd1);
    @(posedge clk); #1;
    flush = 1; ld_en = 0;
    @(negedge clk);
    chk("drain wait stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    flush = 0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    chk("drain stall cycles", n, 3);
    chk("drain load_data kept", load_data, keep);

    // reset in the middle of WAIT
    set_exp(1, 32'h400, 0, 4'b0000, 3'b010, 32'h77777777);
    ld_chk = 0;
    rv_dly = 10;
    cache_rdata = 32'h77777777;
    @(posedge clk); #1;
    ld_en = 1; addr = 32'h400; dm_select = 3'b010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nrst = 0; ld_en = 0; addr = 0; dm_select = 0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk_zero("midwait reset");
    @(posedge clk); #1;
    nrst = 1;
    rv_force = 1;
    @(negedge clk);
    chk("late rvalid stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rv_force = 0;
    @(negedge clk);
    chk("late rvalid load_data", load_data, 32'd0);
    chk("late rvalid dc_req", {31'd0, dc_req}, 32'd0);
    chk("late rvalid stall2", {31'd0, stall}, 32'd0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
